// File: rtl/shift_sequencer_if.sv
// Handshake/operand bundle between the EX-stage issue logic (master) and the
// multi-cycle shift sequencer (slave).
interface shift_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] data;
    logic [31:0]       shamt;
    logic              flush;
    logic [DATA_W-1:0] result;
    logic              busy;
    logic              done;
    logic              stall;

    modport master (
        output start, op, data, shamt, flush,
        input  result, busy, done, stall
    );

    modport slave (
        input  start, op, data, shamt, flush,
        output result, busy, done, stall
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller for SLL/SRL/SRA (and the variable forms) in EX.
// Shifts at most STEP bits per cycle, stalls the pipeline while working and
// reports completion with a single-cycle done pulse.
// Optional feature macro: SHIFT_SEQ_BYPASS_EN -- a zero effective shift amount
// is answered combinationally in the request cycle without leaving IDLE.
module shift_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input logic              clk,
    input logic              rst,
    shift_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    state_e              state;
    op_e                 op_q;
    logic [DATA_W-1:0]   result_q;
    logic [SHAMT_W-1:0]  rem;
    logic                done_q;

    logic [SHAMT_W-1:0]  eff_shamt;
    logic                accept;
    logic                bypass_hit;
    logic [SHAMT_W-1:0]  step_amt;
    logic [DATA_W-1:0]   shifted;
    logic                unused_shamt_hi;

    // Only the low SHAMT_W bits of the zero-extended amount matter.
    assign eff_shamt       = bus.shamt[SHAMT_W-1:0];
    assign unused_shamt_hi = ^bus.shamt[31:SHAMT_W];

    // A request is taken only in IDLE and only when no flush is pending.
    assign accept = (state == ST_IDLE) && bus.start && !bus.flush;

`ifdef SHIFT_SEQ_BYPASS_EN
    assign bypass_hit = accept && (eff_shamt == '0) && !rst;
`else
    assign bypass_hit = 1'b0;
`endif

    // Bits consumed this cycle: the full STEP, or the remainder on the last pass.
    assign step_amt = (rem < STEP_AMT) ? rem : STEP_AMT;

    // One shift pass of the working register according to the captured op.
    always_comb begin
        // NOTE: default first so every path assigns shifted; no latch is inferred.
        shifted = result_q << step_amt;
        case (op_q)
            OP_SRL:  shifted = result_q >> step_amt;
            OP_SRA:  shifted = $signed(result_q) >>> step_amt;
            default: shifted = result_q << step_amt;
        endcase
    end

    // Sequencer FSM: capture in IDLE, shift in SHIFT, pulse done in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_SLL;
            result_q <= '0;
            rem      <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            done_q <= 1'b0;
            if (bus.flush) begin
                // Abort wins over everything but reset; result is left untouched.
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            result_q <= bus.data;
                            op_q     <= op_e'(bus.op);
                            rem      <= eff_shamt;
                            if (eff_shamt != '0) begin
                                state <= ST_SHIFT;
                            end else begin
`ifdef SHIFT_SEQ_BYPASS_EN
                                // Answered combinationally this cycle; stay idle.
                                state <= ST_IDLE;
`else
                                state  <= ST_DONE;
                                done_q <= 1'b1;
`endif
                            end
                        end
                    end
                    ST_SHIFT: begin
                        result_q <= shifted;
                        rem      <= rem - step_amt;
                        if (rem == step_amt) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        // Any start seen here is ignored; it is re-sampled in IDLE.
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Pipeline-facing outputs; reset forces the request-cycle terms low too.
    assign bus.busy   = (state != ST_IDLE);
    assign bus.done   = done_q || bypass_hit;
    assign bus.stall  = (state == ST_SHIFT) || (accept && !bypass_hit && !rst);
    assign bus.result = bypass_hit ? bus.data : result_q;

endmodule
